// File: rtl/if_id_pipe_if.sv
// IF->ID stage bus: upstream handshake, stage controls and registered outputs to ID.
interface if_id_pipe_if #(
    parameter int LANES = 1,
    parameter int INS_W = 32,
    parameter int PC_W  = 32
);
    logic                   flush;
    logic                   stall;
    logic                   halt;
    logic [LANES-1:0]       in_valid;
    logic [LANES*INS_W-1:0] ins_i;
    logic [LANES*PC_W-1:0]  pc_i;
    logic                   in_ready;
    logic [LANES-1:0]       out_valid;
    logic [LANES*INS_W-1:0] ins_o;
    logic [LANES*PC_W-1:0]  pc_o;

    modport slave (
        input  flush, stall, halt, in_valid, ins_i, pc_i,
        output in_ready, out_valid, ins_o, pc_o
    );

    modport master (
        output flush, stall, halt, in_valid, ins_i, pc_i,
        input  in_ready, out_valid, ins_o, pc_o
    );
endinterface

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with a one-entry skid buffer, flush/halt injection
// and saturating stall/flush event counters.
module if_id_pipe #(
    parameter int              LANES    = 1,
    parameter int              INS_W    = 32,
    parameter int              PC_W     = 32,
    parameter logic [INS_W-1:0] HALT_INS = 32'h0000000c,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    if_id_pipe_if.slave      bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int IW = LANES * INS_W;
    localparam int PW = LANES * PC_W;

    typedef enum logic {RUN = 1'b0, SKID = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [LANES-1:0] main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic [IW-1:0]    main_ins_q, main_ins_d, skid_ins_q, skid_ins_d;
    logic [PW-1:0]    main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [IW-1:0]    in_ins_m;
    logic [PW-1:0]    in_pc_m;
    logic [PC_W-1:0]  halt_pc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Invalid lanes are captured as zero so downstream never sees stale fields.
    always_comb begin
        in_ins_m = '0;
        in_pc_m  = '0;
        for (int k = 0; k < LANES; k++) begin
            in_ins_m[k*INS_W +: INS_W] = bus.in_valid[k] ? bus.ins_i[k*INS_W +: INS_W] : '0;
            in_pc_m[k*PC_W +: PC_W]    = bus.in_valid[k] ? bus.pc_i[k*PC_W +: PC_W] : '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        main_vld_d = main_vld_q;
        main_ins_d = main_ins_q;
        main_pc_d  = main_pc_q;
        skid_vld_d = skid_vld_q;
        skid_ins_d = skid_ins_q;
        skid_pc_d  = skid_pc_q;
        halt_pc    = (state_q == RUN) ? bus.pc_i[PC_W-1:0] : skid_pc_q[PC_W-1:0];

        if (bus.flush) begin
            main_vld_d = '0;
            main_ins_d = '0;
            main_pc_d  = '0;
            skid_vld_d = '0;
            skid_ins_d = '0;
            skid_pc_d  = '0;
            state_d    = RUN;
        end else if (bus.halt) begin
            main_vld_d              = '0;
            main_vld_d[0]           = 1'b1;
            main_ins_d              = '0;
            main_ins_d[INS_W-1:0]   = HALT_INS;
            main_pc_d               = '0;
            main_pc_d[PC_W-1:0]     = halt_pc;
            skid_vld_d              = '0;
            skid_ins_d              = '0;
            skid_pc_d               = '0;
            state_d                 = RUN;
        end else if (state_q == RUN) begin
            if (!bus.stall) begin
                main_vld_d = bus.in_valid;
                main_ins_d = in_ins_m;
                main_pc_d  = in_pc_m;
            end else if (|bus.in_valid) begin
                skid_vld_d = bus.in_valid;
                skid_ins_d = in_ins_m;
                skid_pc_d  = in_pc_m;
                state_d    = SKID;
            end
        end else if (!bus.stall) begin
            main_vld_d = skid_vld_q;
            main_ins_d = skid_ins_q;
            main_pc_d  = skid_pc_q;
            skid_vld_d = '0;
            skid_ins_d = '0;
            skid_pc_d  = '0;
            state_d    = RUN;
        end

        stall_cnt_d = (bus.stall && !bus.flush) ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = bus.flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            main_vld_q  <= '0;
            main_ins_q  <= '0;
            main_pc_q   <= '0;
            skid_vld_q  <= '0;
            skid_ins_q  <= '0;
            skid_pc_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_vld_q  <= main_vld_d;
            main_ins_q  <= main_ins_d;
            main_pc_q   <= main_pc_d;
            skid_vld_q  <= skid_vld_d;
            skid_ins_q  <= skid_ins_d;
            skid_pc_q   <= skid_pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Ready depends only on registered state, never on the incoming stall.
    assign bus.in_ready  = (state_q == RUN);
    assign bus.out_valid = main_vld_q;
    assign bus.ins_o     = main_ins_q;
    assign bus.pc_o      = main_pc_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_if_id_pipe.sv
// Directed bench for if_id_pipe: one single-lane instance and one dual-lane
// instance with 2-bit counters, sharing clock and reset.
module tb_if_id_pipe;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    if_id_pipe_if #(.LANES(1), .INS_W(32), .PC_W(32)) if1 ();
    if_id_pipe_if #(.LANES(2), .INS_W(32), .PC_W(32)) if2 ();

    logic [15:0] sc1, fc1;
    logic [1:0]  sc2, fc2;

    if_id_pipe #(.LANES(1), .INS_W(32), .PC_W(32), .HALT_INS(32'h0000000c), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    if_id_pipe #(.LANES(2), .INS_W(32), .PC_W(32), .HALT_INS(32'h0000000c), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .bus(if2.slave), .stall_cnt(sc2), .flush_cnt(fc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv1(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic st, input logic fl, input logic hl);
        if1.in_valid = v;
        if1.ins_i    = ins;
        if1.pc_i     = pc;
        if1.stall    = st;
        if1.flush    = fl;
        if1.halt     = hl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        drv1(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        if2.in_valid = 2'b00; if2.ins_i = '0; if2.pc_i = '0;
        if2.stall = 1'b0; if2.flush = 1'b0; if2.halt = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", {63'd0, if1.out_valid}, 64'd0);
        chk("rst_ready", {63'd0, if1.in_ready}, 64'd1);
        chk("rst_ins",   {32'd0, if1.ins_o}, 64'd0);
        chk("rst_scnt",  {48'd0, sc1}, 64'd0);
        #6 rst = 1'b0;

        // Plain streaming, one cycle latency
        drv1(1'b1, 32'h11, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("s0_ins", {32'd0, if1.ins_o}, 64'h11);
        chk("s0_vld", {63'd0, if1.out_valid}, 64'd1);
        drv1(1'b1, 32'h22, 32'h4, 1'b0, 1'b0, 1'b0);
        tick();
        chk("s1_ins", {32'd0, if1.ins_o}, 64'h22);
        chk("s1_pc",  {32'd0, if1.pc_o}, 64'h4);
        drv1(1'b1, 32'h33, 32'h8, 1'b0, 1'b0, 1'b0);
        tick();
        chk("s2_ins", {32'd0, if1.ins_o}, 64'h33);
        chk("s2_pc",  {32'd0, if1.pc_o}, 64'h8);
        drv1(1'b0, 32'hdead, 32'hbeef, 1'b0, 1'b0, 1'b0);
        tick();
        chk("inv_vld", {63'd0, if1.out_valid}, 64'd0);
        chk("inv_ins", {32'd0, if1.ins_o}, 64'd0);
        chk("inv_pc",  {32'd0, if1.pc_o}, 64'd0);

        // Two-cycle stall with a skid capture
        drv1(1'b1, 32'h11, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        drv1(1'b1, 32'h22, 32'h4, 1'b1, 1'b0, 1'b0);
        tick();
        chk("st1_pc",    {32'd0, if1.pc_o}, 64'h0);
        chk("st1_ins",   {32'd0, if1.ins_o}, 64'h11);
        chk("st1_ready", {63'd0, if1.in_ready}, 64'd0);
        chk("st1_cnt",   {48'd0, sc1}, 64'd1);
        tick();
        chk("st2_pc",    {32'd0, if1.pc_o}, 64'h0);
        chk("st2_ready", {63'd0, if1.in_ready}, 64'd0);
        chk("st2_cnt",   {48'd0, sc1}, 64'd2);
        drv1(1'b1, 32'h99, 32'hc, 1'b0, 1'b0, 1'b0);
        tick();
        chk("drain_pc",    {32'd0, if1.pc_o}, 64'h4);
        chk("drain_ins",   {32'd0, if1.ins_o}, 64'h22);
        chk("drain_ready", {63'd0, if1.in_ready}, 64'd1);
        chk("drain_cnt",   {48'd0, sc1}, 64'd2);
        tick();
        chk("next_ins", {32'd0, if1.ins_o}, 64'h99);
        chk("next_pc",  {32'd0, if1.pc_o}, 64'hc);

        // Flush while the skid is full
        drv1(1'b1, 32'h55, 32'h10, 1'b1, 1'b0, 1'b0);
        tick();
        chk("fl_pre_ready", {63'd0, if1.in_ready}, 64'd0);
        drv1(1'b1, 32'h66, 32'h14, 1'b1, 1'b1, 1'b0);
        tick();
        chk("fl_vld",   {63'd0, if1.out_valid}, 64'd0);
        chk("fl_ins",   {32'd0, if1.ins_o}, 64'd0);
        chk("fl_pc",    {32'd0, if1.pc_o}, 64'd0);
        chk("fl_ready", {63'd0, if1.in_ready}, 64'd1);
        chk("fl_fcnt",  {48'd0, fc1}, 64'd1);
        chk("fl_scnt",  {48'd0, sc1}, 64'd3);

        // Halt overrides stall; flush overrides halt
        drv1(1'b1, 32'h77, 32'h40, 1'b1, 1'b0, 1'b1);
        tick();
        chk("h_ins",  {32'd0, if1.ins_o}, 64'h0000000c);
        chk("h_pc",   {32'd0, if1.pc_o}, 64'h40);
        chk("h_vld",  {63'd0, if1.out_valid}, 64'd1);
        chk("h_scnt", {48'd0, sc1}, 64'd4);
        drv1(1'b1, 32'h77, 32'h40, 1'b1, 1'b1, 1'b1);
        tick();
        chk("hf_vld",  {63'd0, if1.out_valid}, 64'd0);
        chk("hf_ins",  {32'd0, if1.ins_o}, 64'd0);
        chk("hf_fcnt", {48'd0, fc1}, 64'd2);
        chk("hf_scnt", {48'd0, sc1}, 64'd4);

        // Halt in SKID takes its PC from the skid entry
        drv1(1'b1, 32'h88, 32'h80, 1'b1, 1'b0, 1'b0);
        tick();
        chk("hs_pre_ready", {63'd0, if1.in_ready}, 64'd0);
        drv1(1'b1, 32'h89, 32'h44, 1'b1, 1'b0, 1'b1);
        tick();
        chk("hs_pc",    {32'd0, if1.pc_o}, 64'h80);
        chk("hs_ins",   {32'd0, if1.ins_o}, 64'h0000000c);
        chk("hs_ready", {63'd0, if1.in_ready}, 64'd1);
        chk("hs_scnt",  {48'd0, sc1}, 64'd6);
        drv1(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Dual lane: lane 0 invalid is zeroed; 2-bit stall counter saturates
        if2.in_valid = 2'b10;
        if2.ins_i    = {32'hbb, 32'haa};
        if2.pc_i     = {32'h104, 32'h100};
        tick();
        chk("l2_vld", {62'd0, if2.out_valid}, 64'h2);
        chk("l2_ins", if2.ins_o, {32'hbb, 32'h0});
        chk("l2_pc",  if2.pc_o, {32'h104, 32'h0});
        if2.in_valid = 2'b00;
        if2.stall    = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("l2_scnt",  {62'd0, sc2}, 64'd3);
        chk("l2_ready", {63'd0, if2.in_ready}, 64'd1);
        chk("l2_hold",  if2.ins_o, {32'hbb, 32'h0});
        if2.stall = 1'b0;

        // Asynchronous reset between edges, with the skid full
        drv1(1'b1, 32'h12, 32'h20, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ar_pre_vld", {63'd0, if1.out_valid}, 64'd1);
        drv1(1'b1, 32'h34, 32'h24, 1'b1, 1'b0, 1'b0);
        tick();
        chk("ar_pre_ready", {63'd0, if1.in_ready}, 64'd0);
        #3 rst = 1'b1;
        #1;
        chk("ar_vld",   {63'd0, if1.out_valid}, 64'd0);
        chk("ar_ins",   {32'd0, if1.ins_o}, 64'd0);
        chk("ar_pc",    {32'd0, if1.pc_o}, 64'd0);
        chk("ar_scnt",  {48'd0, sc1}, 64'd0);
        chk("ar_fcnt",  {48'd0, fc1}, 64'd0);
        chk("ar_ready", {63'd0, if1.in_ready}, 64'd1);
        chk("ar_l2vld", {62'd0, if2.out_valid}, 64'd0);
        #1 rst = 1'b0;
        drv1(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ar_post_vld", {63'd0, if1.out_valid}, 64'd0);
        chk("ar_post_ins", {32'd0, if1.ins_o}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameter LANES, default 1, number of instruction lanes per stage (legal 1..4).
REQ-002 Parameter INS_W, default 32, instruction width per lane.
REQ-003 Parameter PC_W, default 32, PC width per lane.
REQ-004 Parameter HALT_INS, default 32'h0000000c, instruction injected on halt (INS_W bits).
REQ-005 Parameter CNT_W, default 16, width of event counters.
REQ-006 clk  in  1  single clock, all state updates on posedge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 flush  in  1  jump/branch flush; discards all held instructions.
REQ-009 stall  in  1  downstream hold request.
REQ-010 halt  in  1  replace stage contents with HALT_INS.
REQ-011 in_valid  in  LANES  per-lane valid from IF.
REQ-012 ins_i  in  LANES*INS_W  instructions, lane k at bits [k*INS_W +: INS_W].
REQ-013 pc_i  in  LANES*PC_W  PCs, lane k at bits [k*PC_W +: PC_W].
REQ-014 in_ready  out  1  stage accepts input this cycle.
REQ-015 out_valid  out  LANES  per-lane valid to ID.
REQ-016 ins_o  out  LANES*INS_W  registered instructions to ID.
REQ-017 pc_o  out  LANES*PC_W  registered PCs to ID.
REQ-018 stall_cnt  out  CNT_W  saturating count of stall cycles.
REQ-019 flush_cnt  out  CNT_W  saturating count of flush cycles.

Function
REQ-020 Storage: main register (drives outputs) plus one skid register of identical shape; FSM states RUN (skid empty) and SKID (skid full).
REQ-021 in_ready SHALL be 1 exactly when state is RUN; registered-state derived, no combinational path from stall.
REQ-022 Priority per cycle: flush > halt > stall > normal advance.
REQ-023 RUN, no flush/halt, stall=0: main <= input, out_valid <= in_valid; stays RUN.
REQ-024 RUN, stall=1, any in_valid=1: skid <= input, main held, -> SKID; if in_valid all 0, main held, stays RUN.
REQ-025 SKID, stall=0: main <= skid, skid cleared, -> RUN; input ignored (in_ready=0).
REQ-026 SKID, stall=1: main and skid held, stays SKID.
REQ-027 On every capture, lanes with valid=0 SHALL store ins=0 and pc=0.
REQ-028 flush=1: main and skid cleared (all valid/ins/pc = 0), -> RUN, regardless of stall/halt; input in that cycle discarded.
REQ-029 halt=1 (no flush): lane 0 <= {valid=1, ins=HALT_INS, pc=lane-0 PC of the source}; other lanes cleared; skid cleared; -> RUN; halt overrides stall.
REQ-030 Halt PC source: pc_i lane 0 in RUN, skid lane-0 PC in SKID.
REQ-031 Latency: input accepted in RUN without stall appears on outputs one cycle later; via skid, one cycle after stall deasserts.
REQ-032 stall_cnt increments by 1 each cycle stall=1 and flush=0; saturates at all-ones.
REQ-033 flush_cnt increments by 1 each cycle flush=1; saturates at all-ones.
REQ-034 No instruction accepted while in_ready=1 SHALL be lost or duplicated except by flush or halt.

Reset
REQ-035 rst=1 SHALL immediately (asynchronously) clear main, skid, out_valid, ins_o, pc_o, stall_cnt, flush_cnt to 0 and set state RUN.
REQ-036 After rst deasserts, in_ready=1 and first capture occurs on the next posedge; rst asserted mid-SKID discards skid contents.

Verification
REQ-037 LANES=1, stream ins 0x11,0x22,0x33 pc 0,4,8, no stall -> ins_o shows 0x11,0x22,0x33 on consecutive cycles, one cycle delay.
REQ-038 Stall 2 cycles while pc=4 presented after pc=0 captured -> out holds pc=0, in_ready=0 from next cycle, pc=4 appears cycle after stall drops, stall_cnt=2.
REQ-039 Flush while in SKID -> next cycle out_valid=0, ins_o=0, pc_o=0, in_ready=1, flush_cnt=1.
REQ-040 halt with stall=1, pc_i=0x40 in RUN -> ins_o=0x0000000c, pc_o=0x40, out_valid=1; halt+flush same cycle -> outputs 0.
REQ-041 LANES=2, in_valid=2'b10 -> out_valid=2'b10, lane 0 ins/pc = 0; CNT_W=2 stall held 5 cycles -> stall_cnt=3.
REQ-042 Assert rst asynchronously between clock edges while outputs valid -> outputs and counters 0 before next posedge.
